lcd_de_ctrl: RTL and testbench
==============================

# lcd_de_ctrl

Display-window controller for the 800×480 LCD path. It derives the LCD data-enable window from the scandoubled hsync/vsync using per-video-mode start offsets held in a small configuration table. The MCU can rewrite that table at run time over the existing byte-stream interface. It sits between the scandoubler/OSD output and the LCD pins, so the window can be trimmed per ST mode without rebuilding the bitstream.

## Interface
Parameters:
- H_ACTIVE, 10'd800, visible pixels per line
- V_ACTIVE, 10'd480, visible lines per frame
- CMD_WINDOW, 8'h60, MCU command byte selecting a window write
- X0_RST / Y0_RST, 10'd920 / 10'd990, reset offsets for mode 0 (NTSC)
- X1_RST / Y1_RST, 10'd920 / 10'd930, reset offsets for mode 1 (PAL)
- X2_RST / Y2_RST, 10'd955 / 10'd0, reset offsets for mode 2 (mono)

Ports:
- clk_pixel  in  1  pixel clock; the only clock
- por  in  1  reset; synchronous, active-high
- mcu_start  in  1  level; high while an MCU frame is active
- mcu_strobe  in  1  one-cycle pulse per valid mcu_data byte
- mcu_data  in  8  MCU byte
- vmode  in  2  current video mode (0 NTSC, 1 PAL, 2 mono, 3 treated as 2)
- hs_n  in  1  scandoubled hsync, active-low
- vs_n  in  1  scandoubled vsync, active-low
- lcd_de  out  1  LCD data enable
- hcnt  out  10  horizontal position counter
- vcnt  out  10  vertical position counter
- cfg_ack  out  1  one-cycle pulse when a table entry is written

## Operation
- Table: three entries, each holding {X[9:0], Y[9:0]}. Index = vmode, with 3 mapped to 2. Reset loads the *_RST values.
- Position counters:
  - hs rising edge: hs_n high in this cycle and low in the previous cycle.
  - On an hs rising edge: hcnt ← X[idx]. vs_n is sampled at this point. If vs_n is high and its previous sample (taken at the last hs edge) was low, vcnt ← Y[idx]; otherwise vcnt ← vcnt+1.
  - Every other cycle: hcnt ← hcnt+1.
  - Both counters wrap modulo 1024.
- lcd_de = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE). Combinational from the counter registers.
- Parser FSM states: IDLE, CMD, MODE, XH, XL, YH, YL, SKIP.
  - mcu_start low → IDLE from any state; any partial frame is discarded.
  - mcu_start high in IDLE → CMD.
  - Each mcu_strobe advances the FSM by one byte.
  - CMD: byte == CMD_WINDOW → MODE; any other byte → SKIP.
  - MODE: byte[1:0] is latched. byte > 2 → SKIP, otherwise → XH.
  - XH: byte[1:0] = X[9:8]. XL: X[7:0]. YH: byte[1:0] = Y[9:8].
  - YL: the byte is Y[7:0]. The entry is committed and the FSM goes to SKIP.
  - SKIP ignores all bytes until mcu_start falls.
- Commit: the table entry is written in the cycle after the YL strobe, and cfg_ack pulses in that same cycle.
- Reset mid-frame: the FSM returns to IDLE and the table returns to the *_RST values. Bytes from the remainder of the interrupted frame are ignored until mcu_start falls and rises again.

## Timing
- Reset values: hcnt=10'h3FF, vcnt=10'h3FF, lcd_de=0, cfg_ack=0, FSM=IDLE. Edge-detect history is set to high (inactive).
- First hs rising edge: hcnt is loaded on the cycle after hs_n goes high. lcd_de has zero cycles of latency from hcnt/vcnt.
- Counter load vs. commit:
  - A commit takes effect at the first hs edge strictly after the table write.
  - If a commit and an hs edge fall in the same cycle, the counters load the old value.
- vmode changes take effect at the next hs edge. No glitch occurs within a line.
- A byte accepted while mcu_start is rising: if mcu_strobe and the mcu_start rise coincide, that byte is treated as the CMD byte.
- Throughput: one byte per cycle. Back-to-back strobes are legal.

## Configuration
- LCD_DE_CTRL_SHADOW_EN defined:
  - A commit writes a shadow entry and raises a per-entry pending flag.
  - Pending entries copy into the live table on the next vs rising edge, as detected at an hs edge. That copy happens before the counter load in the same cycle, so the new X and Y apply from that line.
  - cfg_ack still pulses at commit time.
  - A second commit to the same entry before the vs edge overwrites the shadow.
- Not defined: commits write the live table directly, per Operation.

## Test plan
- Reset, vmode=0, hs_n/vs_n idle high:
  - Expect hcnt=vcnt=1023 and lcd_de=0.
  - After the first hs edge, hcnt=920.
- NTSC timing, 1024-cycle lines:
  - After a vs edge, vcnt=990.
  - lcd_de first rises when vcnt wraps to 0 and hcnt wraps to 0.
  - lcd_de stays high for 800 cycles per line over 480 lines.
- MCU write 60,01,00,0A,00,05 with vmode=1:
  - cfg_ack pulses once.
  - The next hs edge loads hcnt=10.
  - The next vs edge loads vcnt=5.
- Aborted frame 60,01,00 followed by mcu_start falling: no cfg_ack, and PAL offsets stay 920/930.
- Invalid frames produce no commit:
  - 60,03,…
  - 61,… (wrong command byte)
- vmode=3: hcnt loads 955 at the hs edge. Commit and hs edge in the same cycle: the old value loads, and the new value loads on the next line.
- With SHADOW_EN: a commit mid-frame leaves hcnt loads unchanged until the vs edge, then the new X applies.

Source files
------------

// File: rtl/lcd_de_ctrl.sv
// LCD data-enable window generator with an MCU-writable per-mode offset table.
// Optional LCD_DE_CTRL_SHADOW_EN: table writes are staged and applied at the next vsync edge.
module lcd_de_ctrl #(
  parameter logic [9:0] H_ACTIVE   = 10'd800,
  parameter logic [9:0] V_ACTIVE   = 10'd480,
  parameter logic [7:0] CMD_WINDOW = 8'h60,
  parameter logic [9:0] X0_RST     = 10'd920,
  parameter logic [9:0] Y0_RST     = 10'd990,
  parameter logic [9:0] X1_RST     = 10'd920,
  parameter logic [9:0] Y1_RST     = 10'd930,
  parameter logic [9:0] X2_RST     = 10'd955,
  parameter logic [9:0] Y2_RST     = 10'd0
) (
  input  logic       clk_pixel,
  input  logic       por,
  input  logic       mcu_start,
  input  logic       mcu_strobe,
  input  logic [7:0] mcu_data,
  input  logic [1:0] vmode,
  input  logic       hs_n,
  input  logic       vs_n,
  output logic       lcd_de,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       cfg_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_MODE, S_XH, S_XL, S_YH, S_YL, S_SKIP
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] mode_reg, mode_next;
  logic [9:0] x_reg, x_next, y_reg, y_next;
  logic       commit_reg, commit_next;
  logic       start_prev_reg, hs_prev_reg, vs_prev_reg;
  logic [9:0] hcnt_reg, vcnt_reg;
  logic       start_rise, hs_rise, vs_rise;
  logic [59:0] live_flat;
  logic [19:0] sel_live, eff_entry;

  assign start_rise = mcu_start & ~start_prev_reg;
  assign hs_rise    = hs_n & ~hs_prev_reg;
  // vs history is only sampled at hs edges, so this is meaningful only with hs_rise
  assign vs_rise    = vs_n & ~vs_prev_reg;

  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    commit_next = 1'b0;
    if (!mcu_start) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // a frame only opens on a fresh rise; a byte on the rise is the command byte
          if (start_rise) begin
            state_next = S_CMD;
            if (mcu_strobe)
              state_next = (mcu_data == CMD_WINDOW) ? S_MODE : S_SKIP;
          end
        end
        S_CMD:  if (mcu_strobe) state_next = (mcu_data == CMD_WINDOW) ? S_MODE : S_SKIP;
        S_MODE: if (mcu_strobe) begin
          mode_next  = mcu_data[1:0];
          state_next = (mcu_data > 8'd2) ? S_SKIP : S_XH;
        end
        S_XH: if (mcu_strobe) begin x_next[9:8] = mcu_data[1:0]; state_next = S_XL; end
        S_XL: if (mcu_strobe) begin x_next[7:0] = mcu_data;      state_next = S_YH; end
        S_YH: if (mcu_strobe) begin y_next[9:8] = mcu_data[1:0]; state_next = S_YL; end
        S_YL: if (mcu_strobe) begin
          y_next[7:0] = mcu_data;
          commit_next = 1'b1;
          state_next  = S_SKIP;
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (por) begin
      state_reg      <= S_IDLE;
      mode_reg       <= 2'd0;
      x_reg          <= 10'd0;
      y_reg          <= 10'd0;
      commit_reg     <= 1'b0;
      start_prev_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      mode_reg       <= mode_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      commit_reg     <= commit_next;
      start_prev_reg <= mcu_start;
    end
  end

`ifdef LCD_DE_CTRL_SHADOW_EN
  logic [59:0] shadow_flat;
  logic [2:0]  pend_flat;
  logic [19:0] sel_shadow;
  logic        sel_pend;
  logic        copy_en;
  assign copy_en = hs_rise & vs_rise;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_entry
      localparam logic [19:0] RST_VAL = (gi == 0) ? {X0_RST, Y0_RST} :
                                        (gi == 1) ? {X1_RST, Y1_RST} : {X2_RST, Y2_RST};
      logic [19:0] live_reg;
      logic        hit;
      assign hit = commit_reg && (mode_reg == 2'(gi));
      assign live_flat[gi*20 +: 20] = live_reg;
`ifdef LCD_DE_CTRL_SHADOW_EN
      logic [19:0] shadow_reg;
      logic        pend_reg;
      assign shadow_flat[gi*20 +: 20] = shadow_reg;
      assign pend_flat[gi] = pend_reg;
      always_ff @(posedge clk_pixel) begin
        if (por) begin
          live_reg   <= RST_VAL;
          shadow_reg <= RST_VAL;
          pend_reg   <= 1'b0;
        end else begin
          if (copy_en && pend_reg) begin
            live_reg <= shadow_reg;
            pend_reg <= 1'b0;
          end
          // a commit on the copy cycle stays pending for the following frame
          if (hit) begin
            shadow_reg <= {x_reg, y_reg};
            pend_reg   <= 1'b1;
          end
        end
      end
`else
      always_ff @(posedge clk_pixel) begin
        if (por)
          live_reg <= RST_VAL;
        else if (hit)
          live_reg <= {x_reg, y_reg};
      end
`endif
    end
  endgenerate

  always_comb begin
    sel_live = live_flat[59:40];
    case (vmode)
      2'd0:    sel_live = live_flat[19:0];
      2'd1:    sel_live = live_flat[39:20];
      default: sel_live = live_flat[59:40];
    endcase
  end

`ifdef LCD_DE_CTRL_SHADOW_EN
  always_comb begin
    sel_shadow = shadow_flat[59:40];
    sel_pend   = pend_flat[2];
    case (vmode)
      2'd0:    begin sel_shadow = shadow_flat[19:0];  sel_pend = pend_flat[0]; end
      2'd1:    begin sel_shadow = shadow_flat[39:20]; sel_pend = pend_flat[1]; end
      default: begin sel_shadow = shadow_flat[59:40]; sel_pend = pend_flat[2]; end
    endcase
  end
  // the vsync copy lands in the same cycle as the load, so bypass it onto the counters
  assign eff_entry = (copy_en && sel_pend) ? sel_shadow : sel_live;
`else
  assign eff_entry = sel_live;
`endif

  always_ff @(posedge clk_pixel) begin
    if (por) begin
      hcnt_reg    <= 10'h3FF;
      vcnt_reg    <= 10'h3FF;
      hs_prev_reg <= 1'b1;
      vs_prev_reg <= 1'b1;
    end else begin
      hs_prev_reg <= hs_n;
      if (hs_rise) begin
        hcnt_reg    <= eff_entry[19:10];
        vs_prev_reg <= vs_n;
        vcnt_reg    <= vs_rise ? eff_entry[9:0] : vcnt_reg + 10'd1;
      end else begin
        hcnt_reg <= hcnt_reg + 10'd1;
      end
    end
  end

  assign hcnt    = hcnt_reg;
  assign vcnt    = vcnt_reg;
  assign lcd_de  = (hcnt_reg < H_ACTIVE) && (vcnt_reg < V_ACTIVE);
  assign cfg_ack = commit_reg;

endmodule

// File: tb/tb_lcd_de_ctrl.sv
// Bench for lcd_de_ctrl: vector table, directed MCU/timing sequences and random traffic vs a frame-level model.
module tb_lcd_de_ctrl;

  logic       clk_pixel = 1'b0;
  logic       por, mcu_start, mcu_strobe, hs_n, vs_n;
  logic [7:0] mcu_data;
  logic [1:0] vmode;
  logic       lcd_de, cfg_ack;
  logic [9:0] hcnt, vcnt;

  lcd_de_ctrl dut (
    .clk_pixel(clk_pixel), .por(por), .mcu_start(mcu_start), .mcu_strobe(mcu_strobe),
    .mcu_data(mcu_data), .vmode(vmode), .hs_n(hs_n), .vs_n(vs_n),
    .lcd_de(lcd_de), .hcnt(hcnt), .vcnt(vcnt), .cfg_ack(cfg_ack)
  );

  always #5 clk_pixel = ~clk_pixel;

`ifdef LCD_DE_CTRL_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0;

  // reference model: position arithmetic plus whole-frame decoding of MCU bytes
  int  m_h, m_v, c_ent, c_x, c_y;
  bit  m_ack, m_hs_prev, m_vs_prev, m_armed;
  int  m_x[3], m_y[3], s_x[3], s_y[3];
  bit  s_pend[3];
  byte unsigned frame_q[$];

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_h = 1023; m_v = 1023; m_ack = 0;
    m_hs_prev = 1; m_vs_prev = 1; m_armed = 0;
    frame_q.delete();
    m_x = '{920, 920, 955};
    m_y = '{990, 930, 0};
    s_x = m_x; s_y = m_y;
    s_pend = '{0, 0, 0};
  endfunction

  function automatic void model_step();
    int idx;
    bit vs_edge;
    if (por) begin
      model_reset();
      return;
    end
    idx = (vmode == 2'd3) ? 2 : int'(vmode);
    if (hs_n && !m_hs_prev) begin
      vs_edge = vs_n && !m_vs_prev;
      if (SHADOW && vs_edge)
        for (int i = 0; i < 3; i++)
          if (s_pend[i]) begin m_x[i] = s_x[i]; m_y[i] = s_y[i]; s_pend[i] = 0; end
      m_h = m_x[idx];
      m_v = vs_edge ? m_y[idx] : (m_v + 1) % 1024;
      m_vs_prev = vs_n;
    end else begin
      m_h = (m_h + 1) % 1024;
    end
    m_hs_prev = hs_n;
    if (m_ack) begin
      if (SHADOW) begin s_x[c_ent] = c_x; s_y[c_ent] = c_y; s_pend[c_ent] = 1; end
      else        begin m_x[c_ent] = c_x; m_y[c_ent] = c_y; end
    end
    m_ack = 0;
    if (!mcu_start) begin
      frame_q.delete();
      m_armed = 1;
    end else if (m_armed && mcu_strobe) begin
      frame_q.push_back(mcu_data);
      if (frame_q.size() == 6 && frame_q[0] == 8'h60 && frame_q[1] <= 8'd2) begin
        m_ack = 1;
        c_ent = int'(frame_q[1]);
        c_x = int'(frame_q[2] & 8'h03) * 256 + int'(frame_q[3]);
        c_y = int'(frame_q[4] & 8'h03) * 256 + int'(frame_q[5]);
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk_pixel);
    #1;
    cyc++;
    model_step();
    check("hcnt", int'(hcnt), m_h);
    check("vcnt", int'(vcnt), m_v);
    check("lcd_de", int'(lcd_de), int'(m_h < 800 && m_v < 480));
    check("cfg_ack", int'(cfg_ack), int'(m_ack));
    if (cfg_ack) ack_cnt++;
  endtask

  task automatic hs_edge();
    hs_n = 1'b0; tick();
    hs_n = 1'b1; tick();
  endtask

  task automatic vs_edge();
    vs_n = 1'b0; hs_edge();
    vs_n = 1'b1; hs_edge();
  endtask

  // first byte coincides with the mcu_start rise; mcu_start is left high afterwards
  task automatic send_frame(input logic [7:0] b[6], input int n);
    mcu_start = 1'b0; mcu_strobe = 1'b0; tick();
    mcu_start = 1'b1;
    for (int i = 0; i < n; i++) begin
      mcu_strobe = 1'b1; mcu_data = b[i]; tick();
    end
    mcu_strobe = 1'b0;
  endtask

  task automatic end_frame();
    tick();
    mcu_start = 1'b0; tick();
  endtask

  task automatic run_line(input bit vs_val, output int de_cnt);
    de_cnt = 0;
    vs_n = vs_val;
    for (int c = 0; c < 1024; c++) begin
      hs_n = (c < 8) ? 1'b0 : 1'b1;
      tick();
      if (lcd_de) de_cnt++;
    end
  endtask

  typedef struct {
    bit       rst;
    bit       hs;
    bit       vs;
    bit [1:0] vm;
    int       eh;
    int       ev;
    bit       ede;
  } vec_t;

  vec_t vecs[14];
  logic [7:0] fr[6];
  int de_cnt, ack_base, pos;

  initial begin
    vecs[0]  = '{1, 1, 1, 2'd0, 1023, 1023, 0};
    vecs[1]  = '{0, 0, 1, 2'd0,    0, 1023, 0};
    vecs[2]  = '{0, 1, 1, 2'd0,  920,    0, 0};
    vecs[3]  = '{0, 1, 0, 2'd0,  921,    0, 0};
    vecs[4]  = '{0, 0, 0, 2'd0,  922,    0, 0};
    vecs[5]  = '{0, 1, 0, 2'd0,  920,    1, 0};
    vecs[6]  = '{0, 0, 1, 2'd0,  921,    1, 0};
    vecs[7]  = '{0, 1, 1, 2'd0,  920,  990, 0};
    vecs[8]  = '{0, 1, 1, 2'd1,  921,  990, 0};
    vecs[9]  = '{0, 0, 1, 2'd1,  922,  990, 0};
    vecs[10] = '{0, 1, 1, 2'd1,  920,  991, 0};
    vecs[11] = '{0, 0, 1, 2'd3,  921,  991, 0};
    vecs[12] = '{0, 1, 1, 2'd3,  955,  992, 0};
    vecs[13] = '{0, 1, 1, 2'd3,  956,  992, 0};

    por = 1'b1; mcu_start = 1'b0; mcu_strobe = 1'b0; mcu_data = 8'h00;
    vmode = 2'd0; hs_n = 1'b1; vs_n = 1'b1;
    model_reset();

    for (int i = 0; i < 14; i++) begin
      por = vecs[i].rst; hs_n = vecs[i].hs; vs_n = vecs[i].vs; vmode = vecs[i].vm;
      tick();
      check("vec_hcnt", int'(hcnt), vecs[i].eh);
      check("vec_vcnt", int'(vcnt), vecs[i].ev);
      check("vec_de", int'(lcd_de), int'(vecs[i].ede));
      $display("vec %0d: hcnt=%0d vcnt=%0d de=%0d", i, hcnt, vcnt, lcd_de);
    end

    // NTSC with 1024-cycle lines: window opens when vcnt wraps to 0
    por = 1'b1; vmode = 2'd0; hs_n = 1'b1; vs_n = 1'b1; tick();
    por = 1'b0;
    run_line(1'b0, de_cnt);
    run_line(1'b1, de_cnt);
    check("ntsc_vs_load", int'(vcnt), 990);
    for (int l = 0; l < 33; l++) run_line(1'b1, de_cnt);
    check("ntsc_v1023", int'(vcnt), 1023);
    check("ntsc_de_before_wrap", de_cnt, 0);
    run_line(1'b1, de_cnt);
    check("ntsc_de_line0", de_cnt, 800);
    run_line(1'b1, de_cnt);
    check("ntsc_de_line1", de_cnt, 800);
    $display("ntsc run: vcnt=%0d de cycles on last line=%0d", vcnt, de_cnt);

    // MCU write to the PAL entry
    ack_base = ack_cnt;
    vmode = 2'd1;
    fr = '{8'h60, 8'h01, 8'h00, 8'h0A, 8'h00, 8'h05};
    send_frame(fr, 6);
    end_frame();
    check("write_ack_once", ack_cnt - ack_base, 1);
    hs_edge();
    check("write_h_next_edge", int'(hcnt), SHADOW ? 920 : 10);
    vs_edge();
    check("write_h_after_vs", int'(hcnt), 10);
    check("write_v_after_vs", int'(vcnt), 5);
    $display("mcu write: hcnt=%0d vcnt=%0d acks=%0d", hcnt, vcnt, ack_cnt - ack_base);

    // aborted frame after a fresh reset leaves PAL offsets alone
    por = 1'b1; tick(); por = 1'b0;
    ack_base = ack_cnt;
    send_frame(fr, 3);
    mcu_start = 1'b0; tick();
    check("abort_no_ack", ack_cnt - ack_base, 0);
    vs_edge();
    check("abort_pal_x", int'(hcnt), 920);
    check("abort_pal_y", int'(vcnt), 930);
    $display("aborted frame: hcnt=%0d vcnt=%0d", hcnt, vcnt);

    // invalid mode byte and wrong command byte
    ack_base = ack_cnt;
    fr = '{8'h60, 8'h03, 8'h00, 8'h0A, 8'h00, 8'h05};
    send_frame(fr, 6); end_frame();
    fr = '{8'h61, 8'h01, 8'h00, 8'h0A, 8'h00, 8'h05};
    send_frame(fr, 6); end_frame();
    check("invalid_no_ack", ack_cnt - ack_base, 0);
    $display("invalid frames: acks=%0d", ack_cnt - ack_base);

    // vmode 3, commit coinciding with an hs edge
    vmode = 2'd3; hs_n = 1'b0;
    fr = '{8'h60, 8'h02, 8'h01, 8'h23, 8'h00, 8'h07};
    send_frame(fr, 6);
    check("coincide_ack", int'(cfg_ack), 1);
    hs_n = 1'b1; tick();
    check("coincide_old_x", int'(hcnt), 955);
    hs_edge();
    check("coincide_new_x", int'(hcnt), SHADOW ? 955 : 291);
    mcu_start = 1'b0; tick();
    vs_edge();
    check("coincide_after_vs", int'(hcnt), 291);
    check("coincide_after_vs_y", int'(vcnt), 7);
    $display("coincide: hcnt=%0d vcnt=%0d", hcnt, vcnt);

    // random traffic against the model
    pos = 0;
    for (int i = 0; i < 20000; i++) begin
      por = ($urandom_range(0, 999) == 0);
      if (!mcu_start) mcu_start = ($urandom_range(0, 7) == 0);
      else            mcu_start = ($urandom_range(0, 39) != 0);
      if (!mcu_start) pos = 0;
      mcu_strobe = $urandom_range(0, 1) == 1;
      case (pos)
        0:       mcu_data = ($urandom_range(0, 7) == 0) ? 8'h61 : 8'h60;
        1:       mcu_data = 8'($urandom_range(0, 3));
        default: mcu_data = 8'($urandom);
      endcase
      if (mcu_start && mcu_strobe) pos++;
      if ($urandom_range(0, 3) == 0) hs_n = ~hs_n;
      if ($urandom_range(0, 15) == 0) vs_n = ~vs_n;
      if ($urandom_range(0, 63) == 0) vmode = 2'($urandom);
      tick();
    end
    $display("random phase done: total acks=%0d", ack_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
